nonce_sweep_controller: RTL

Sequences one mining job at a time through the pipelined final-hash processor chain. Accepts a job over a valid/ready handshake and streams one candidate nonce per cycle into the chain, starting with a newblock-flagged beat. Counts returning results, captures the first victory and its nonce, drains in-flight work, then reports found or exhausted before accepting the next job. Sits between the job source (host/UART front end) and the head of the processor chain; its result inputs come from the tail of the chain.

---
 rtl/mining_pkg.sv | 19 +
 rtl/result_tracker.sv | 48 ++++
 rtl/nonce_sweep_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mining_pkg.sv
// Shared mining types: hash state, sweep controller state encoding and width defaults.
package mining_pkg;

  localparam int NONCEBITS_DEF     = 32;
  localparam int JOBBITS_DEF       = 352;
  localparam int PARTITIONBITS_DEF = 1;

  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } HashState;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } nonce_sweep_state_e;

endpackage

// File: rtl/result_tracker.sv
// Counts results returning from the chain tail and captures the first winning nonce of a job.
module result_tracker #(
  parameter int PARTITIONBITS = 1,
  parameter int NONCEBITS     = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             track,
  input  logic                             valid_final,
  input  logic                             newblock_final,
  input  logic                             victory,
  input  logic [PARTITIONBITS-1:0]         nonce_start,
  output logic [NONCEBITS-PARTITIONBITS:0] r_next,
  output logic                             win,
  output logic [NONCEBITS-1:0]             found_nonce
);

  localparam int S = NONCEBITS - PARTITIONBITS;
  localparam logic [S:0] one = (S+1)'(1);

  logic [S:0]   r_q;
  logic [S-1:0] sub_nonce;

  // Results come back in issue order, so the running count is the sub-nonce of the next result.
  always_comb begin
    r_next    = r_q;
    sub_nonce = newblock_final ? '0 : r_q[S-1:0];
    if (track && valid_final) begin
      r_next = newblock_final ? one : r_q + one;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_q         <= '0;
      win         <= 1'b0;
      found_nonce <= '0;
    end else begin
      r_q <= r_next;
      if (track && valid_final && victory && !win) begin
        win         <= 1'b1;
        found_nonce <= {nonce_start, sub_nonce};
      end
    end
  end

endmodule

// File: rtl/nonce_sweep_controller.sv
// Issues one candidate nonce per cycle for the current job, drains the chain, then reports.
// Handshake: a job transfers on the rising edge where job_valid && job_ready are both high.
module nonce_sweep_controller
  import mining_pkg::*;
#(
  parameter int PARTITIONBITS = PARTITIONBITS_DEF,
  parameter int NONCEBITS     = NONCEBITS_DEF,
  parameter int JOBBITS       = JOBBITS_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               job_valid,
  output logic                               job_ready,
  input  logic [JOBBITS-1:0]                 job_data,
  input  logic                               abort,
  output logic                               core_valid,
  output logic                               core_newblock,
  output logic [JOBBITS-1:0]                 core_data,
  output logic [NONCEBITS-PARTITIONBITS-1:0] core_nonce,
  input  logic                               valid_final,
  input  logic                               newblock_final,
  input  logic                               victory,
  input  logic [PARTITIONBITS-1:0]           nonce_start,
  output logic                               found_valid,
  output logic [NONCEBITS-1:0]               found_nonce,
  output logic                               exhausted,
  output logic                               busy
);

  localparam int S = NONCEBITS - PARTITIONBITS;
  localparam logic [S:0] sweep_len = {1'b1, {S{1'b0}}};
  localparam logic [S:0] one       = (S+1)'(1);

  nonce_sweep_state_e state, state_next;

  logic [S:0] issue_q;
  logic [S:0] r_next;
  logic       aborted_q;
  logic       win;
  logic       accept;
  logic       track;
  logic       victory_hit;
  logic       stop_issue;

  assign accept      = (state == ST_IDLE) && job_valid;
  assign track       = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign victory_hit = track && valid_final && victory;
  assign stop_issue  = (issue_q == sweep_len) || victory_hit || abort;

  result_tracker #(
    .PARTITIONBITS (PARTITIONBITS),
    .NONCEBITS     (NONCEBITS)
  ) u_result_tracker (
    .clk            (clk),
    .rst            (rst),
    .clear          (accept),
    .track          (track),
    .valid_final    (valid_final),
    .newblock_final (newblock_final),
    .victory        (victory),
    .nonce_start    (nonce_start),
    .r_next         (r_next),
    .win            (win),
    .found_nonce    (found_nonce)
  );

  always_comb begin
    state_next  = state;
    job_ready   = 1'b0;
    found_valid = 1'b0;
    exhausted   = 1'b0;
    case (state)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) state_next = ST_ISSUE;
      end
      ST_ISSUE:  if (stop_issue) state_next = ST_DRAIN;
      // r_next already includes a result landing this cycle.
      ST_DRAIN:  if (r_next == issue_q) state_next = ST_REPORT;
      ST_REPORT: begin
        found_valid = win;
        exhausted   = !win && !aborted_q;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Beats are registered: the beat for count I is loaded on the edge that moves I to I+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      issue_q       <= '0;
      aborted_q     <= 1'b0;
      core_valid    <= 1'b0;
      core_newblock <= 1'b0;
      core_nonce    <= '0;
      core_data     <= '0;
    end else begin
      state         <= state_next;
      core_valid    <= 1'b0;
      core_newblock <= 1'b0;
      if (accept) begin
        core_data     <= job_data;
        core_valid    <= 1'b1;
        core_newblock <= 1'b1;
        core_nonce    <= '0;
        issue_q       <= one;
        aborted_q     <= 1'b0;
      end else if (state == ST_ISSUE) begin
        if (stop_issue) begin
          aborted_q <= abort && !victory_hit;
        end else begin
          core_valid <= 1'b1;
          core_nonce <= issue_q[S-1:0];
          issue_q    <= issue_q + one;
        end
      end
    end
  end

endmodule
